// File: rtl/change_reset_gen_if.sv
// Bundle of the mode/control inputs and reset/status outputs
// of change_reset_gen.
interface change_reset_gen_if #(
  parameter int NUM_CTRL = 3,
  parameter int MODE_W   = 1,
  parameter int COUNT_W  = 8
);
  logic [MODE_W-1:0]   mode_sel;
  logic [NUM_CTRL-1:0] ctrl;
  logic [NUM_CTRL-1:0] ctrl_mask;
  logic                resetter;
  logic                busy;
  logic [NUM_CTRL:0]   cause;
  logic [COUNT_W-1:0]  event_count;

  modport master (
    output mode_sel,
    output ctrl,
    output ctrl_mask,
    input  resetter,
    input  busy,
    input  cause,
    input  event_count
  );

  modport slave (
    input  mode_sel,
    input  ctrl,
    input  ctrl_mask,
    output resetter,
    output busy,
    output cause,
    output event_count
  );
endinterface

// File: rtl/change_reset_gen.sv
// Debounced mode/control change detector driving a stretched reset pulse.
// CHANGE_RESET_CAUSE_EN enables the cause and event_count registers.
module change_reset_gen #(
  parameter int NUM_CTRL      = 3,
  parameter int MODE_W        = 1,
  parameter logic [(1<<MODE_W)-1:0] ACTIVE_MODES = 2'b10,
  parameter int SETTLE_CYCLES = 2,
  parameter int PULSE_LEN     = 4,
  parameter int COUNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  change_reset_gen_if.slave bus
);

  localparam int MAXC =
    (SETTLE_CYCLES > PULSE_LEN) ? SETTLE_CYCLES : PULSE_LEN;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    PULSE  = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [MODE_W-1:0]   mode_q;
  logic [NUM_CTRL-1:0] ctrl_q;
  logic [MODE_W-1:0]   cand_mode;
  logic [NUM_CTRL-1:0] cand_ctrl;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       pcnt;
  logic                pulse_active;

  logic [NUM_CTRL-1:0] elig;
  logic                diff;
  logic                same_cand;
  logic                settled;
  logic                commit;
  logic                pulse_done;

  always_comb begin
    elig = bus.ctrl_mask
         & {NUM_CTRL{ACTIVE_MODES[bus.mode_sel]}};
    diff = (bus.mode_sel != mode_q)
         | (|((bus.ctrl ^ ctrl_q) & elig));
    same_cand = (bus.mode_sel == cand_mode)
              & ~(|((bus.ctrl ^ cand_ctrl) & elig));
    settled    = (cnt == CW'(SETTLE_CYCLES - 1));
    commit     = (state == SETTLE) & diff
               & same_cand & settled;
    pulse_done = (pcnt == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (diff) state_n = SETTLE;
      end
      SETTLE: begin
        if (!diff)       state_n = IDLE;
        else if (commit) state_n = PULSE;
      end
      PULSE: begin
        if (pulse_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state != IDLE);
    bus.resetter = ~rst | pulse_active;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q       <= bus.mode_sel;
      ctrl_q       <= bus.ctrl;
      cand_mode    <= '0;
      cand_ctrl    <= '0;
      cnt          <= '0;
      pcnt         <= '0;
      pulse_active <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // ineligible bits follow silently so they never look changed
          ctrl_q <= (ctrl_q & elig) | (bus.ctrl & ~elig);
          if (diff) begin
            cand_mode <= bus.mode_sel;
            cand_ctrl <= bus.ctrl;
            cnt       <= '0;
          end
        end
        SETTLE: begin
          if (diff && !same_cand) begin
            cand_mode <= bus.mode_sel;
            cand_ctrl <= bus.ctrl;
            cnt       <= '0;
          end else if (commit) begin
            mode_q       <= cand_mode;
            ctrl_q       <= cand_ctrl;
            pulse_active <= 1'b1;
            pcnt         <= CW'(PULSE_LEN - 1);
          end else if (diff) begin
            cnt <= cnt + 1'b1;
          end
        end
        PULSE: begin
          if (pulse_done) pulse_active <= 1'b0;
          else            pcnt <= pcnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CHANGE_RESET_CAUSE_EN
  logic [NUM_CTRL:0]  cause_q;
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cause_q <= '0;
      count_q <= '0;
    end else if (commit) begin
      cause_q <= {cand_mode != mode_q,
                  (cand_ctrl ^ ctrl_q) & elig};
      if (count_q != '1) count_q <= count_q + 1'b1;
    end
  end

  assign bus.cause       = cause_q;
  assign bus.event_count = count_q;
`else
  assign bus.cause       = '0;
  assign bus.event_count = '0;
`endif

endmodule

// File: tb/tb_change_reset_gen.sv
// Scoreboard bench for change_reset_gen: expected pulses are queued
// by the stimulus and matched by a monitor on the falling edge.
module tb_change_reset_gen;

  typedef struct {
    int         start;
    int         len;
    logic [3:0] cause;
    int         count;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   ev;
  exp_t q[$];

  change_reset_gen_if #(
    .NUM_CTRL(3), .MODE_W(1), .COUNT_W(8)
  ) bus ();

  change_reset_gen dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] ec(input logic [3:0] c);
`ifdef CHANGE_RESET_CAUSE_EN
    return c;
`else
    return 4'b0 & c;
`endif
  endfunction

  function automatic int ecnt(input int n);
`ifdef CHANGE_RESET_CAUSE_EN
    return (n > 255) ? 255 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic push(input logic [3:0] c, input int len);
    exp_t e;
    ev = ev + 1;
    e.start = cyc + 3;
    e.len   = len;
    e.cause = ec(c);
    e.count = ecnt(ev);
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: a pulse is resetter high while rst is released
  initial begin
    bit   in_pulse;
    bit   have;
    int   len;
    exp_t e;
    in_pulse = 0;
    have = 0;
    len = 0;
    forever begin
      @(negedge clk);
      if (rst && bus.resetter && !in_pulse) begin
        in_pulse = 1;
        len = 1;
        chk("pulse_expected", q.size() != 0, 1);
        have = (q.size() != 0);
        if (have) begin
          e = q.pop_front();
          chk("pulse_start", cyc, e.start);
          chk("cause", bus.cause, e.cause);
          chk("event_count", bus.event_count, e.count);
        end
      end else if (rst && bus.resetter) begin
        len = len + 1;
      end else if (in_pulse) begin
        in_pulse = 0;
        if (have) chk("pulse_len", len, e.len);
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    ev = 0;
    rst = 1'b0;
    bus.mode_sel  = 1'b1;
    bus.ctrl      = 3'b101;
    bus.ctrl_mask = 3'b111;
    step(3);
    chk("rst_resetter", bus.resetter, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.event_count, 0);
    chk("rst_cause", bus.cause, 0);
    rst = 1'b1;
    step(1);
    chk("rel_resetter", bus.resetter, 0);
    step(8);
    chk("rel_count", bus.event_count, 0);

    bus.mode_sel = 1'b0;
    push(4'b1000, 4);
    step(10);
    chk("idle_busy", bus.busy, 0);
    bus.mode_sel = 1'b1;
    push(4'b1000, 4);
    step(10);

    bus.ctrl = 3'b111;
    step(1);
    chk("glitch_busy_hi", bus.busy, 1);
    bus.ctrl = 3'b101;
    step(1);
    chk("glitch_busy_lo", bus.busy, 0);
    step(8);

    bus.mode_sel = 1'b0;
    push(4'b1000, 4);
    step(10);
    bus.ctrl = 3'b010;
    step(2);
    chk("mode0_busy_a", bus.busy, 0);
    bus.ctrl = 3'b111;
    step(2);
    chk("mode0_busy_b", bus.busy, 0);
    step(6);
    bus.mode_sel = 1'b1;
    push(4'b1000, 4);
    step(10);

    bus.ctrl = 3'b000;
    push(4'b0111, 4);
    step(10);
    bus.ctrl = 3'b001;
    step(1);
    bus.ctrl = 3'b011;
    push(4'b0011, 4);
    step(12);

    bus.ctrl_mask = 3'b000;
    step(2);
    bus.mode_sel = 1'b0;
    push(4'b1000, 4);
    for (int i = 0; i < 10; i++) begin
      bus.ctrl = bus.ctrl ^ 3'b101;
      step(1);
    end
    step(4);

    bus.mode_sel = 1'b1;
    push(4'b1000, 2);
    step(5);
    rst = 1'b0;
    step(2);
    chk("abort_resetter", bus.resetter, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_count", bus.event_count, 0);
    chk("abort_cause", bus.cause, 0);
    rst = 1'b1;
    ev = 0;
    bus.ctrl_mask = 3'b111;
    step(8);
    chk("post_abort_busy", bus.busy, 0);

    for (int i = 0; i < 258; i++) begin
      bus.mode_sel = ~bus.mode_sel;
      push(4'b1000, 4);
      step(8);
    end
    step(4);
    chk("sat_count", bus.event_count, ecnt(ev));
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
